// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - dot-product accumulator behind a pipelined multiplier
//
// Accumulates the product stream y of multiplierArray into dot products of up
// to vlen terms. The multiplier carries no valid, so in_valid/in_last are
// delayed here by `latency` cycles to line up with y.
//
// Build option: MAC_ACCUMULATOR_SATURATE_EN clamps the sum to all-ones on
// carry-out instead of wrapping.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     a/b presented to the multiplier this cycle
//   in_last      final term of the current vector (qualified by in_valid)
//   y            product from the multiplier, 2*width bits
//   out_valid    one-cycle pulse, out_sum/out_overflow valid
//   out_sum      completed dot product, 2*width+guard bits (held after pulse)
//   out_overflow carry-out occurred within this vector (held after pulse)
//   busy         vector partially accumulated or products in flight

module mac_accumulator #(
  parameter int width   = 64,
  parameter int latency = 2,
  parameter int vlen    = 16,
  parameter int guard   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [2*width-1:0]       y,
  output logic                     out_valid,
  output logic [2*width+guard-1:0] out_sum,
  output logic                     out_overflow,
  output logic                     busy
);

  localparam int pw = 2 * width;
  localparam int aw = pw + guard;
  localparam int cw = $clog2(vlen + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state, state_n;
  logic [aw-1:0]   acc, acc_n;
  logic [cw-1:0]   cnt, cnt_n;
  logic            sticky, sticky_n;

  logic            pv, pl, inflight;

  // Valid/last delay line matched to the multiplier depth.
  generate
    if (latency == 0) begin : g_pass
      assign pv       = in_valid;
      assign pl       = in_valid & in_last;
      assign inflight = 1'b0;
    end else begin : g_dly
      logic [latency-1:0] vchain;
      logic [latency-1:0] lchain;

      always_ff @(posedge clk) begin
        if (rst) begin
          vchain <= '0;
          lchain <= '0;
        end else begin
          vchain[0] <= in_valid;
          // in_last without in_valid is dropped here so it can never close a vector.
          lchain[0] <= in_valid & in_last;
          for (int i = 1; i < latency; i++) begin
            vchain[i] <= vchain[i-1];
            lchain[i] <= lchain[i-1];
          end
        end
      end

      assign pv       = vchain[latency-1];
      assign pl       = lchain[latency-1];
      assign inflight = |vchain;
    end
  endgenerate

  // In IDLE the running sum starts from zero, so one adder serves both states.
  logic [aw-1:0] base;
  logic [cw-1:0] cnt_inc;
  logic [aw:0]   sum_ext;
  logic          carry;
  logic          ovf_now;
  logic [aw-1:0] sum_v;
  logic          close;
  logic          emit;

  always_comb begin
    base     = (state == ACCUM) ? acc : '0;
    cnt_inc  = ((state == ACCUM) ? cnt : '0) + cw'(1);
    sum_ext  = {1'b0, base} + {{(guard + 1){1'b0}}, y};
    carry    = sum_ext[aw];
    ovf_now  = ((state == ACCUM) & sticky) | carry;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    // Once clamped, later adds either carry again or add zero, so it stays clamped.
    sum_v    = ovf_now ? '1 : sum_ext[aw-1:0];
`else
    sum_v    = sum_ext[aw-1:0];
`endif
    close    = pl | (cnt_inc == cw'(vlen));

    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    sticky_n = sticky;
    emit     = 1'b0;

    if (pv) begin
      if (close) begin
        emit     = 1'b1;
        acc_n    = '0;
        cnt_n    = '0;
        sticky_n = 1'b0;
        state_n  = IDLE;
      end else begin
        acc_n    = sum_v;
        cnt_n    = cnt_inc;
        sticky_n = ovf_now;
        state_n  = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      sticky       <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      acc       <= acc_n;
      cnt       <= cnt_n;
      sticky    <= sticky_n;
      out_valid <= emit;
      if (emit) begin
        out_sum      <= sum_v;
        out_overflow <= ovf_now;
      end
    end
  end

  assign busy = (state == ACCUM) | inflight;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - scoreboard bench for mac_accumulator (vlen 16 and 17)

module tb_mac_accumulator;

  localparam int W  = 8;
  localparam int SW = 2 * W + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2*W-1:0] p1, p2;

  logic          ov0, ov1, of0, of1, busy0, busy1;
  logic [SW-1:0] os0, os1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage multiplier stand-in: y lags a/b by two clocks.
  always @(posedge clk) begin
    p1 <= a * b;
    p2 <= p1;
  end

  mac_accumulator #(.width(W), .latency(2), .vlen(16), .guard(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .y(p2),
    .out_valid(ov0), .out_sum(os0), .out_overflow(of0), .busy(busy0));

  mac_accumulator #(.width(W), .latency(2), .vlen(17), .guard(4)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .y(p2),
    .out_valid(ov1), .out_sum(os1), .out_overflow(of1), .busy(busy1));

  typedef struct {
    logic [SW-1:0] sum;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: running true sum and term count per instance.
  longint tot[2];
  int     cnt[2];
  int     vl[2] = '{16, 17};

  int            nout[2]     = '{0, 0};
  logic [SW-1:0] last_sum[2];
  logic [SW-1:0] prev_sum[2];
  logic          last_ovf[2];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_term(input int k, input longint prod, input logic l, input int ecyc);
    exp_t   e;
    longint lim;
    lim = longint'(1) << SW;
    tot[k] += prod;
    cnt[k]++;
    if (l || cnt[k] == vl[k]) begin
      e.ovf = (tot[k] >= lim);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      e.sum = e.ovf ? SW'(lim - 1) : SW'(tot[k]);
`else
      e.sum = SW'(tot[k] % lim);
`endif
      e.cyc = ecyc;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      tot[k] = 0;
      cnt[k] = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic l);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = av;
    b        = bv;
    in_last  = l;
    if (v) begin
      for (int k = 0; k < 2; k++) model_term(k, longint'(av) * longint'(bv), l, cyc + 3);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic mon(input int k, input logic v, input logic [SW-1:0] s, input logic o);
    exp_t e;
    if (v) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out[%0d]: got sum %0d with no expected result queued", k, s);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("sum[%0d]", k), longint'(s), longint'(e.sum));
        check($sformatf("ovf[%0d]", k), longint'(o), longint'(e.ovf));
        check($sformatf("cycle[%0d]", k), longint'(cyc), longint'(e.cyc));
      end
      nout[k]++;
      prev_sum[k] = last_sum[k];
      last_sum[k] = s;
      last_ovf[k] = o;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ov0, os0, of0);
      mon(1, ov1, os1, of1);
    end
  end

  int n0;

  initial begin
    tot = '{0, 0};
    cnt = '{0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(ov0), 0);
    check("rst_out_sum", longint'(os0), 0);
    check("rst_out_overflow", longint'(of0), 0);
    check("rst_busy", longint'(busy0 | busy1), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Three-term vector.
    n0 = nout[0];
    drive(1, 3, 4, 0);
    drive(1, 5, 6, 0);
    drive(1, 7, 8, 1);
    idle(5);
    check("t1_pulses", longint'(nout[0] - n0), 1);
    check("t1_sum", longint'(last_sum[0]), 98);
    check("t1_hold_sum", longint'(os0), 98);

    // Back-to-back vectors with no gap.
    n0 = nout[0];
    drive(1, 2, 2, 0);
    drive(1, 3, 3, 1);
    drive(1, 10, 10, 1);
    idle(5);
    check("b2b_pulses", longint'(nout[0] - n0), 2);
    check("b2b_first", longint'(prev_sum[0]), 13);
    check("b2b_second", longint'(last_sum[0]), 100);

    // Auto-close at 16 terms, then a lone (1,1).
    for (int i = 0; i < 16; i++) drive(1, 255, 255, 0);
    drive(1, 1, 1, 1);
    idle(5);
    check("auto_close_sum", longint'(prev_sum[0]), 1040400);
    check("after_close_sum", longint'(last_sum[0]), 1);
    check("vlen17_nowrap", longint'(last_sum[1]), 1040401);

    // 17 full-scale terms on the vlen=17 instance.
    for (int i = 0; i < 17; i++) drive(1, 255, 255, i == 16);
    idle(5);
    check("ovf17_flag", longint'(last_ovf[1]), 1);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    check("ovf17_sum", longint'(last_sum[1]), 1048575);
`else
    check("ovf17_sum", longint'(last_sum[1]), 56849);
`endif

    // Reset with two of four terms issued and still in flight.
    n0 = nout[0];
    drive(1, 6, 7, 0);
    drive(1, 8, 9, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    tot      = '{0, 0};
    cnt      = '{0, 0};
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", longint'(busy0 | busy1), 0);
    idle(4);
    check("rst_mid_no_pulse", longint'(nout[0] - n0), 0);
    drive(1, 1, 9, 1);
    idle(5);
    check("post_rst_sum", longint'(last_sum[0]), 9);

    // Gapped vector: busy must stay high across the idle cycles.
    drive(1, 4, 4, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("gap_busy%0d", i), longint'(busy0), 1);
    end
    drive(1, 2, 2, 1);
    idle(5);
    check("gap_sum", longint'(last_sum[0]), 20);

    // Randomised traffic, including stray in_last on idle cycles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        drive(0, W'($urandom), W'($urandom), 1'($urandom));
      else
        drive(1, W'($urandom), W'($urandom), $urandom_range(0, 5) == 0);
    end
    drive(1, W'($urandom), W'($urandom), 1);
    idle(8);

    check("q16_drained", longint'(q0.size()), 0);
    check("q17_drained", longint'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
